// File: rtl/vga_sync_generator.sv
// vga_sync_generator: VGA raster timing with registered, blanked RGB and active-low syncs
module vga_sync_generator #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  red_in,
  input  logic [3:0]  green_in,
  input  logic [3:0]  blue_in,
  output logic [31:0] row,
  output logic [31:0] col,
  output logic        frame_start,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL) > 10 ? $clog2(H_TOTAL) : 10;
  localparam int VW = $clog2(V_TOTAL) > 10 ? $clog2(V_TOTAL) : 10;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_START = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_START = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [11:0]   rgb_q, rgb_d;
  logic          hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  logic          tick, h_wrap, v_wrap, video_on;

  assign col         = video_on ? 32'(h_q) : '0;
  assign row         = video_on ? 32'(v_q) : '0;
  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign frame_start = fs_q;

  // Next-state: counters advance on the pixel tick; the output stage samples the pixel being left
  always_comb begin
    tick     = div_q == DIV_LAST;
    h_wrap   = h_q == H_LAST;
    v_wrap   = v_q == V_LAST;
    video_on = (h_q < H_VIS) && (v_q < V_VIS);
    div_d    = tick ? '0 : div_q + DW'(1);
    h_d      = !tick ? h_q : h_wrap ? '0 : h_q + HW'(1);
    v_d      = !(tick && h_wrap) ? v_q : v_wrap ? '0 : v_q + VW'(1);
    rgb_d    = !tick ? rgb_q : video_on ? {red_in, green_in, blue_in} : '0;
    hs_d     = !tick ? hs_q : !(h_q >= HS_START && h_q < HS_END);
    vs_d     = !tick ? vs_q : !(v_q >= VS_START && v_q < VS_END);
    fs_d     = tick && h_wrap && v_wrap;
  end

  // State registers; reset puts the raster at (0,0) with syncs idle and colour blanked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      rgb_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      rgb_q <= rgb_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      fs_q  <= fs_d;
    end
  end
endmodule

// File: tb/tb_vga_sync_generator.sv
// tb_vga_sync_generator: random-colour raster check against an arithmetic timing model on a shrunk mode
module tb_vga_sync_generator;
  localparam int CD = 2;
  localparam int HV = 16, HF = 2, HS = 3, HB = 3;
  localparam int VV = 8,  VF = 2, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT * CD;
  localparam int HS0 = HV + HF;
  localparam int VS0 = VV + VF;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [11:0] key = 12'h000;
  logic [3:0]  red_in, green_in, blue_in;
  logic [31:0] row, col;
  logic        frame_start, vga_hs, vga_vs;
  logic [3:0]  vga_r, vga_g, vga_b;

  int errors = 0, checks = 0;
  int n;
  int exp_rgb, exp_hs, exp_vs, exp_fs;
  int hs_run, vs_run, last_fs, max_row, max_col;
  bit hs_seen, vs_seen;

  assign red_in   = row[3:0] ^ key[3:0];
  assign green_in = col[3:0] ^ key[7:4];
  assign blue_in  = key[11:8];

  vga_sync_generator #(
    .CLK_DIV(CD), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .row(row), .col(col), .frame_start(frame_start), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at n=%0d: got %0d expected %0d", tag, n, got, exp);
    end
  endtask

  // Raster position after t pixel ticks since reset release
  function automatic void pos(input int t, output int h, output int v);
    h = t % HT;
    v = (t / HT) % VT;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_hs"}, vga_hs, 1);
    check({tag, "_vs"}, vga_vs, 1);
    check({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
    check({tag, "_fs"}, frame_start, 0);
    check({tag, "_row"}, row, 0);
    check({tag, "_col"}, col, 0);
  endtask

  task automatic start_segment();
    n = 0;
    exp_rgb = 0; exp_hs = 1; exp_vs = 1; exp_fs = 0;
    hs_run = 0; vs_run = 0; last_fs = -1; max_row = 0; max_col = 0;
    hs_seen = 0; vs_seen = 0;
  endtask

  task automatic run(input int cycles);
    int h, v, h2, v2, vis;
    bit tk;
    for (int i = 0; i < cycles; i++) begin
      pos(n / CD, h, v);
      vis = (h < HV && v < VV) ? 1 : 0;
      tk = ((n + 1) % CD) == 0;
      if (tk) begin
        exp_rgb = vis ? {v[3:0] ^ key[3:0], h[3:0] ^ key[7:4], key[11:8]} : 0;
        exp_hs  = (h >= HS0 && h < HS0 + HS) ? 0 : 1;
        exp_vs  = (v >= VS0 && v < VS0 + VS) ? 0 : 1;
      end
      exp_fs = (tk && h == HT - 1 && v == VT - 1) ? 1 : 0;
      @(posedge clk);
      #1;
      n++;
      pos(n / CD, h2, v2);
      vis = (h2 < HV && v2 < VV) ? 1 : 0;
      check("col", col, vis ? h2 : 0);
      check("row", row, vis ? v2 : 0);
      check("rgb", {vga_r, vga_g, vga_b}, exp_rgb);
      check("hs", vga_hs, exp_hs);
      check("vs", vga_vs, exp_vs);
      check("frame_start", frame_start, exp_fs);
      if (int'(row) > max_row) max_row = row;
      if (int'(col) > max_col) max_col = col;
      if (!vga_hs) begin
        if (!hs_seen) begin
          check("hs_first_fall", n, (HS0 + 1) * CD);
          hs_seen = 1;
        end
        hs_run++;
      end else if (hs_run > 0) begin
        check("hs_width", hs_run, HS * CD);
        hs_run = 0;
      end
      if (!vga_vs) begin
        if (!vs_seen) begin
          check("vs_first_fall", n, (VS0 * HT + 1) * CD);
          vs_seen = 1;
        end
        vs_run++;
      end else if (vs_run > 0) begin
        check("vs_width", vs_run, VS * HT * CD);
        vs_run = 0;
      end
      if (frame_start) begin
        check("fs_period", n - (last_fs < 0 ? 0 : last_fs), FRAME);
        last_fs = n;
      end
      if (tk) key = 12'($urandom);
    end
  endtask

  initial begin
    key = 12'($urandom);
    repeat (5) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    start_segment();
    run(2 * FRAME + 5 + $urandom_range(0, FRAME - 1));
    check("max_col", max_col, HV - 1);
    check("max_row", max_row, VV - 1);
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    @(posedge clk);
    #1;
    check_reset_values("midreset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    start_segment();
    run(FRAME + 3 * CD);
    check("fs_seen_after_reset", last_fs, FRAME);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
